lapido_fetch_queue: RTL and testbench



---
 rtl/lapido_fetch_queue.sv | 91 +++++++++
 tb/tb_lapido_fetch_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lapido_fetch_queue.sv
// Instruction fetch queue between IF and ID: DEPTH-entry FIFO of {pc, instruction}.
// Optional LAPIDO_FQ_BYPASS_EN: an empty queue forwards the fetch straight to ID the same cycle.
module lapido_fetch_queue #(
    parameter int                     INSTR_WIDTH = 32,
    parameter int                     PC_WIDTH    = 32,
    parameter int                     DEPTH       = 4,
    parameter int                     CNT_WIDTH   = $clog2(DEPTH + 1),
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_valid,
    output logic                   fetch_ready,
    input  logic [INSTR_WIDTH-1:0] fetch_instruction,
    input  logic [PC_WIDTH-1:0]    fetch_pc,
    input  logic                   flush,
    input  logic                   stall_pipeline,
    output logic                   out_valid,
    output logic [INSTR_WIDTH-1:0] out_instruction,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [CNT_WIDTH-1:0]   count
);
    localparam int                   PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] FULL  = CNT_WIDTH'(DEPTH);
    localparam logic [PTR_W-1:0]     LAST  = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    entry_t           storage [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             q_valid, push, pop;

    // DEPTH need not be a power of two, so wrap on compare rather than overflow
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign fetch_ready = (count < FULL);
    assign q_valid     = (count != '0);
    assign pop         = q_valid & ~stall_pipeline & ~flush;

`ifdef LAPIDO_FQ_BYPASS_EN
    logic bypass;
    assign bypass    = ~q_valid & fetch_valid & ~flush;
    // a bypassed entry that ID takes this cycle never lands in storage
    assign push      = fetch_valid & fetch_ready & ~flush & ~(bypass & ~stall_pipeline);
    assign out_valid = q_valid | bypass;
    assign head      = bypass ? entry_t'{pc: fetch_pc, instr: fetch_instruction} : storage[rd_ptr];
`else
    assign push      = fetch_valid & fetch_ready & ~flush;
    assign out_valid = q_valid;
    assign head      = storage[rd_ptr];
`endif

    assign out_instruction = out_valid ? head.instr : NOP_WORD;
    assign out_pc          = out_valid ? head.pc : '0;

    always_ff @(posedge clk) begin
        if (push) storage[wr_ptr] <= entry_t'{pc: fetch_pc, instr: fetch_instruction};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) count <= FULL);
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && count == FULL));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));
`endif
endmodule

// File: tb/tb_lapido_fetch_queue.sv
// Scoreboard bench for lapido_fetch_queue (DEPTH=4); driver queues expected entries, monitor pops on consumption.
module tb_lapido_fetch_queue;
`ifdef LAPIDO_FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_instruction = '0;
    logic [31:0] fetch_pc = '0;
    logic        flush = 1'b0;
    logic        stall_pipeline = 1'b0;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [2:0]  count;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    exp_t exp_q[$];
    int n_pass = 0;
    int n_total = 0;

    lapido_fetch_queue #(.INSTR_WIDTH(32), .PC_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_instruction(fetch_instruction), .fetch_pc(fetch_pc),
        .flush(flush), .stall_pipeline(stall_pipeline),
        .out_valid(out_valid), .out_instruction(out_instruction), .out_pc(out_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change at posedge+1; acc says whether the bench expects this fetch to be taken
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic st, input logic fl, input logic acc);
        fetch_valid       = v;
        fetch_pc          = pc;
        fetch_instruction = ins;
        stall_pipeline    = st;
        flush             = fl;
        if (fl) exp_q.delete();
        if (acc) exp_q.push_back('{pc: pc, instr: ins});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [31:0] pc, input logic st,
                       input logic fl, input logic acc);
        drive(v, pc, instr_of(pc), st, fl, acc);
        step();
    endtask

    // Monitor: the head is consumed at the next edge when valid, not stalled, not flushed
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !stall_pipeline && !flush) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_out: got pc %0h expected no entry", out_pc);
                end else begin
                    chk("out_entry", {out_pc, out_instruction}, {exp_q[0].pc, exp_q[0].instr});
                    void'(exp_q.pop_front());
                end
            end else if (!out_valid) begin
                chk("idle_nop", {out_pc, out_instruction}, 64'h0);
            end
        end
    end

    initial begin
        // Reset then idle
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instruction), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);

        // Ordered flow: one cycle behind pushes, occupancy stays at most 1
        cyc(1, 32'h00, 0, 0, 1);
        chk("ord_count0", 64'(count), BYP ? 64'd0 : 64'd1);
        cyc(1, 32'h04, 0, 0, 1);
        chk("ord_count1", 64'(count), BYP ? 64'd0 : 64'd1);
        cyc(1, 32'h08, 0, 0, 1);
        chk("ord_count2", 64'(count), BYP ? 64'd0 : 64'd1);
        cyc(0, 32'h00, 0, 0, 0);
        chk("ord_drained", 64'(count), 64'd0);

        // Fill under stall, overflow attempt ignored
        for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 1, 0, 1);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_ready", 64'(fetch_ready), 64'd0);
        cyc(1, 32'h10, 1, 0, 0);
        chk("full_hold_count", 64'(count), 64'd4);
        // Stall released while full: 0x14 refused this cycle, IF holds it
        cyc(1, 32'h14, 0, 0, 0);
        chk("full_pop_count", 64'(count), 64'd3);
        for (int i = 0; i < 6; i++) cyc(1, 32'h14 + 32'(i * 4), 0, 0, 1);
        chk("wrap_count", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 0, 0, 0);
        chk("wrap_drained", 64'(count), 64'd0);
        chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

        // Flush with a simultaneous push and pop
        for (int i = 0; i < 3; i++) cyc(1, 32'h30 + 32'(i * 4), 1, 0, 1);
        chk("pre_flush_count", 64'(count), 64'd3);
        cyc(1, 32'h40, 0, 1, 0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_pc", 64'(out_pc), 64'd0);
        cyc(1, 32'h44, 0, 1, 0);
        chk("flush_hold_count", 64'(count), 64'd0);
        cyc(0, 32'h0, 0, 0, 0);
        cyc(0, 32'h0, 0, 0, 0);
        chk("post_flush_count", 64'(count), 64'd0);

        // Asynchronous reset between edges
        cyc(1, 32'h50, 1, 0, 1);
        cyc(1, 32'h54, 1, 0, 1);
        chk("pre_rst_count", 64'(count), 64'd2);
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(fetch_ready), 64'd1);
        step();
        rst = 1'b0;
        step();

        // Empty-queue latency: zero with bypass, one cycle without
        drive(1, 32'h20, 32'h8C010004, 0, 0, 1);
        #1;
`ifdef LAPIDO_FQ_BYPASS_EN
        chk("byp_out_valid", 64'(out_valid), 64'd1);
        chk("byp_out_pc", 64'(out_pc), 64'h20);
        chk("byp_out_instr", 64'(out_instruction), 64'h8C010004);
        step();
        chk("byp_take_count", 64'(count), 64'd0);
        drive(1, 32'h20, 32'h8C010004, 1, 0, 1);
        #1;
        chk("byp_stall_valid", 64'(out_valid), 64'd1);
        step();
        chk("byp_stall_count", 64'(count), 64'd1);
`else
        chk("nobyp_out_valid", 64'(out_valid), 64'd0);
        chk("nobyp_out_pc", 64'(out_pc), 64'd0);
        step();
        chk("nobyp_count", 64'(count), 64'd1);
`endif
        cyc(0, 32'h0, 0, 0, 0);
        chk("final_count", 64'(count), 64'd0);
        cyc(0, 32'h0, 0, 0, 0);
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
